// File: rtl/pcd_pkg.sv
// Shared constants, state encoding and the pair-to-bit decision helper
// for the pcd_pair_combiner receive/send datapath.
package pcd_pkg;

  localparam int N_IN   = 8640;
  localparam int N_OUT  = 4320;
  localparam int W      = 8;
  localparam int IN_AW  = 14;
  localparam int OUT_AW = 13;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RECV     = 3'd1,
    DONE     = 3'd2,
    SEND     = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

  // Hard decision on a symbol pair: sign of the 9-bit sum, so -128 + -128 cannot overflow
  function automatic logic pair_bit(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {a[W-1], a} + {b[W-1], b};
    return sum[W];
  endfunction

endpackage

// File: rtl/pcd_bit_ram.sv
// 4320x1 single-clock bit buffer: one write port, one registered read port
// whose flop is cleared by reset and whenever no read is requested.
module pcd_bit_ram
  import pcd_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [OUT_AW-1:0] wr_addr_i,
  input  logic              wr_data_i,
  input  logic              rd_en_i,
  input  logic [OUT_AW-1:0] rd_addr_i,
  output logic              rd_data_o
);

  logic mem_q [N_OUT];
  logic rd_data_q;

  // Storage array write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read; idle reads return 0 so the serial output rests low
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_data_q <= 1'b0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= 1'b0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pcd_pair_combiner.sv
// Collects a frame of soft symbols, turns each pair into a hard bit, then
// pulses frame_finish and streams the buffered bits out one per clock.
module pcd_pair_combiner
  import pcd_pkg::*;
(
  input  logic         clk_in,
  input  logic         reset,
  input  logic [W-1:0] symbol_din,
  input  logic         frame_start,
  output logic         ldpc_dout,
  output logic         frame_finish
);

  state_t             state_q, state_d;
  logic [IN_AW-1:0]   in_cnt_q, in_cnt_d;
  logic [OUT_AW-1:0]  out_cnt_q, out_cnt_d;
  logic [W-1:0]       hold_q, hold_d;
  logic               finish_q, finish_d;
  logic               fs_prev_q;
  logic               we_s;
  logic               wr_bit_s;
  logic [OUT_AW-1:0]  wr_addr_s;
  logic               rd_en_s;
  logic [OUT_AW-1:0]  rd_addr_s;

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    hold_d    = hold_q;
    finish_d  = 1'b0;
    we_s      = 1'b0;
    wr_bit_s  = pair_bit(hold_q, symbol_din);
    wr_addr_s = in_cnt_q[IN_AW-1:1];
    rd_en_s   = 1'b0;
    rd_addr_s = out_cnt_q;
    case (state_q)
      IDLE: begin
        if (frame_start && !fs_prev_q) begin
          hold_d   = symbol_din;
          in_cnt_d = 14'd1;
          state_d  = RECV;
        end else begin
          state_d  = IDLE;
        end
      end
      RECV: begin
        if (!frame_start) begin
          in_cnt_d = 14'd0;
          hold_d   = 8'd0;
          state_d  = IDLE;
        end else begin
          if (in_cnt_q[0]) begin
            we_s   = 1'b1;
          end else begin
            hold_d = symbol_din;
          end
          // Last sample: launch the read of bit 0 so it lands with frame_finish
          if (in_cnt_q == IN_AW'(N_IN - 1)) begin
            in_cnt_d  = 14'd0;
            finish_d  = 1'b1;
            rd_en_s   = 1'b1;
            rd_addr_s = 13'd0;
            out_cnt_d = 13'd1;
            state_d   = DONE;
          end else begin
            in_cnt_d  = in_cnt_q + 14'd1;
          end
        end
      end
      DONE: begin
        rd_en_s   = 1'b1;
        out_cnt_d = out_cnt_q + 13'd1;
        state_d   = SEND;
      end
      SEND: begin
        rd_en_s = 1'b1;
        if (out_cnt_q == OUT_AW'(N_OUT - 1)) begin
          out_cnt_d = 13'd0;
          state_d   = WAIT_LOW;
        end else begin
          out_cnt_d = out_cnt_q + 13'd1;
        end
      end
      WAIT_LOW: begin
        if (!frame_start) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_LOW;
        end
      end
      default: begin
        state_d   = IDLE;
        in_cnt_d  = 14'd0;
        out_cnt_d = 13'd0;
        hold_d    = 8'd0;
      end
    endcase
  end

  // State and counter registers; edge history resets high so a level held
  // through reset is not mistaken for a new frame
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q   <= IDLE;
      in_cnt_q  <= 14'd0;
      out_cnt_q <= 13'd0;
      hold_q    <= 8'd0;
      finish_q  <= 1'b0;
      fs_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      hold_q    <= hold_d;
      finish_q  <= finish_d;
      fs_prev_q <= frame_start;
    end
  end

  pcd_bit_ram u_bit_ram (
    .clk_i     (clk_in),
    .rst_n_i   (reset),
    .we_i      (we_s & reset),
    .wr_addr_i (wr_addr_s),
    .wr_data_i (wr_bit_s),
    .rd_en_i   (rd_en_s & reset),
    .rd_addr_i (rd_addr_s),
    .rd_data_o (ldpc_dout)
  );

  assign frame_finish = finish_q;

endmodule

// File: tb/tb_pcd_pair_combiner.sv
// Directed bench for pcd_pair_combiner: reset hold-off, constant, alternating,
// boundary-sum, busy-ignore and abort frames with hand-derived bit patterns.
module tb_pcd_pair_combiner;

  localparam int NI = 8640;
  localparam int NO = 4320;

  logic       clk_in = 1'b0;
  logic       reset;
  logic [7:0] symbol_din;
  logic       frame_start;
  logic       ldpc_dout;
  logic       frame_finish;

  int n_assert = 0;
  int n_fail   = 0;
  int ff_count = 0;

  pcd_pair_combiner dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .symbol_din   (symbol_din),
    .frame_start  (frame_start),
    .ldpc_dout    (ldpc_dout),
    .frame_finish (frame_finish)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (frame_finish === 1'b1) ff_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Mode 0: all +100; 1: pairs (-50,-50),(+50,+50); 2: boundary pairs; 3: scrambled ramp
  function automatic int stim(input int mode, input int i);
    int p;
    p = i / 2;
    case (mode)
      0: return 100;
      1: return (p % 2 == 0) ? -50 : 50;
      2: case (p % 4)
           0: return -128;
           1: return 127;
           2: return (i % 2 == 0) ? -1 : 1;
           default: return (i % 2 == 0) ? -2 : 1;
         endcase
      default: return ((i * 37 + 11) % 256) - 128;
    endcase
  endfunction

  function automatic logic exp_bit(input int mode, input int k);
    logic [3:0] bnd;
    bnd = 4'b1001;
    case (mode)
      0: return 1'b0;
      1: return (k % 2 == 0) ? 1'b1 : 1'b0;
      2: return bnd[3 - (k % 4)];
      default: return ((stim(3, 2 * k) + stim(3, 2 * k + 1)) < 0) ? 1'b1 : 1'b0;
    endcase
  endfunction

  task automatic run_frame(input int mode, input bit busy);
    int base;
    base = ff_count;
    for (int i = 0; i < NI; i++) begin
      frame_start = 1'b1;
      symbol_din  = 8'(stim(mode, i));
      @(posedge clk_in); #1;
    end
    if (!busy) frame_start = 1'b0;
    symbol_din = 8'h5a;
    @(negedge clk_in);
    chk("finish_pulse", {31'd0, frame_finish}, 32'd1);
    chk("bit0", {31'd0, ldpc_dout}, {31'd0, exp_bit(mode, 0)});
    for (int k = 1; k < NO; k++) begin
      if (busy && k == 100) frame_start = 1'b0;
      if (busy && k == 110) frame_start = 1'b1;
      @(negedge clk_in);
      chk("bit", {31'd0, ldpc_dout}, {31'd0, exp_bit(mode, k)});
    end
    @(negedge clk_in);
    chk("dout_after", {31'd0, ldpc_dout}, 32'd0);
    @(negedge clk_in);
    chk("dout_after2", {31'd0, ldpc_dout}, 32'd0);
    chk("finish_count", ff_count - base, 32'd1);
  endtask

  initial begin
    int base;
    reset       = 1'b0;
    frame_start = 1'b1;
    symbol_din  = 8'd100;
    for (int c = 0; c < 10; c++) @(negedge clk_in);
    chk("rst_dout", {31'd0, ldpc_dout}, 32'd0);
    chk("rst_finish", {31'd0, frame_finish}, 32'd0);

    // frame_start already high at release must not start a frame
    @(posedge clk_in); #1;
    reset = 1'b1;
    for (int c = 0; c < NI + 10; c++) @(negedge clk_in);
    chk("rst_no_accept", ff_count, 32'd0);
    chk("rst_idle_dout", {31'd0, ldpc_dout}, 32'd0);
    frame_start = 1'b0;
    @(negedge clk_in); @(negedge clk_in);

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(2, 1'b1);

    // frame_start still high after the busy frame: nothing new may start
    base = ff_count;
    for (int c = 0; c < 20; c++) @(negedge clk_in);
    chk("busy_no_restart", ff_count - base, 32'd0);
    chk("busy_dout_idle", {31'd0, ldpc_dout}, 32'd0);
    frame_start = 1'b0;
    @(negedge clk_in); @(negedge clk_in);

    base = ff_count;
    for (int i = 0; i < 5000; i++) begin
      frame_start = 1'b1;
      symbol_din  = 8'(stim(3, i));
      @(posedge clk_in); #1;
    end
    frame_start = 1'b0;
    for (int c = 0; c < 4; c++) @(negedge clk_in);
    chk("abort_no_finish", ff_count - base, 32'd0);
    chk("abort_dout", {31'd0, ldpc_dout}, 32'd0);
    run_frame(3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pcd_pair_combiner.md
Name: pcd_pair_combiner

Overview:
- Receiver-side combining block in the OFDM chain, placed between the pilot-demodulator (pdmod) output and the LDPC decoder input.
- Accepts one frame of 8640 8-bit signed soft symbols, serially.
- Combines each consecutive pair of symbols into one hard bit, giving 4320 bits per frame.
- When the frame is complete, pulses frame_finish and streams the 4320 bits out serially, one per clock.

Parameters:
- N_IN, 8640, input symbols per frame.
- N_OUT, 4320, output bits per frame; must equal N_IN/2.
- W, 8, soft symbol width, two's complement.

Ports:
- clk_in  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- symbol_din  input  8  signed soft symbol; sampled every cycle while receiving.
- frame_start  input  1  level; held high for the whole input frame.
- ldpc_dout  output  1  serial decoded bit stream to the LDPC stage.
- frame_finish  output  1  one-cycle pulse marking the start of output.

Behaviour:
- Reset (reset low at a clk_in edge) clears all state:
  - state goes to IDLE; counters go to 0; the pair accumulator is cleared.
  - ldpc_dout = 0, frame_finish = 0.
  - The bit buffer contents need not be cleared.
- State machine: IDLE -> RECV -> DONE -> SEND -> WAIT_LOW -> IDLE.
- IDLE:
  - Leave IDLE only when frame_start = 1 and was 0 on the previous cycle.
  - The first sample (index 0) is taken in that same cycle.
- RECV:
  - Sample symbol_din on every cycle; keep a 14-bit index i from 0 to 8639.
  - Even i: hold the sample.
  - Odd i: form the 9-bit signed sum of the held and current samples; bit = sum[8] (1 when the sum is negative, mapping BPSK 0->+, 1->-); write bit to buffer address i>>1.
  - A sum of exactly zero gives bit 0.
  - After i = 8639, go to DONE.
  - If frame_start falls before 8640 samples, abort: discard the partial frame, emit no frame_finish, return to IDLE.
- DONE:
  - Lasts 1 cycle, on the cycle after the last sample.
  - frame_finish = 1 and ldpc_dout = buffer[0] in this cycle.
- SEND:
  - Output bit k appears on ldpc_dout exactly k cycles after the frame_finish cycle, for k = 0..4319; contiguous, no gaps.
  - After bit 4319, ldpc_dout returns to 0.
  - ldpc_dout = 0 whenever no bit is being sent.
  - Latency from the last input sample to bit 0: 1 cycle.
- WAIT_LOW:
  - If frame_start is still high, wait here until it falls, then go to IDLE.
  - One frame is accepted per frame_start high period.
- While in DONE, SEND or WAIT_LOW, new frame_start edges and symbol_din are ignored.
- The output buffer is a 4320x1 synchronous-write RAM.
- Read is registered so that ldpc_dout is a flop output.
- Address counters are 13 bits (out) and 14 bits (in); neither counter may wrap past N-1.
- Reset mid-frame or mid-send: all activity stops at the next edge; outputs are 0 from that edge on.

Decomposition:
- Shared package pcd_pkg holds:
  - constants N_IN, N_OUT, W;
  - the state enum (IDLE, RECV, DONE, SEND, WAIT_LOW);
  - the address widths IN_AW = 14 and OUT_AW = 13.
- One sub-module: pcd_bit_ram, a 4320x1 single-clock RAM with one write port and one registered read port.

Test Plan:
- Reset:
  - Stimulus: hold reset low 10 cycles with frame_start = 1.
  - Required: ldpc_dout = 0, frame_finish = 0; no frame accepted until a new rising edge of frame_start after reset goes high.
- All-positive frame:
  - Stimulus: 8640 samples of +100.
  - Required: frame_finish pulses once, 1 cycle after the last sample; 4320 zeros follow; ldpc_dout = 0 afterwards.
- Alternating pairs:
  - Stimulus: pairs (-50,-50), (+50,+50) repeated.
  - Required: output 1,0,1,0,... for 4320 bits, bit 0 = 1 in the frame_finish cycle.
- Boundary sums:
  - Stimulus: pairs (-128,-128), (+127,+127), (-1,+1), (-2,+1).
  - Required: bits 1, 0, 0, 1; no overflow, because the 9-bit sum is used.
- Abort:
  - Stimulus: drop frame_start after 5000 samples, then send a full frame.
  - Required: no frame_finish for the partial frame; the full frame decodes correctly.
- Busy ignore:
  - Stimulus: re-raise frame_start during SEND.
  - Required: the stream continues uninterrupted; a new frame is accepted only after a fresh rising edge seen in IDLE.
